logic_op_pipe: RTL and testbench

LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

---
 rtl/logic_op_pipe.sv | 163 ++++++++++++++++
 tb/tb_logic_op_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// logic_op_pipe
//   Applies a bitwise logic operation (AND/OR/XOR/NAND) to two operands and
//   carries the result through a ready/valid pipeline of STAGES registers.
//   It also counts completed output handshakes in a saturating counter.
//
// Parameters
//   WIDTH   operand / result width in bits (1..64)
//   STAGES  number of register stages from input to output (1..4)
//   CNT_W   width of the completed-transfer counter (1..32)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   input transaction present
//   in_ready   block accepts the input transaction this cycle (combinational)
//   in_a       operand A
//   in_b       operand B
//   in_op      operation select: 00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  result present at the output
//   out_ready  downstream accepts the result
//   out_c      result
//   out_zero   out_c is all zeros (qualified by out_valid)
//   cnt_clr    synchronous clear of xfer_cnt
//   xfer_cnt   saturating count of completed output handshakes
module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_zero,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bitwise operation selected by op.
  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = a & b;
      2'b01:   res = a | b;
      2'b10:   res = a ^ b;
      2'b11:   res = ~(a & b);
      default: res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  // True when every bit of the value is zero.
  function automatic logic zero_detect(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] zero_r;
  logic [WIDTH-1:0]  data_r [STAGES];
  logic [STAGES-1:0] load_s;
  logic [WIDTH-1:0]  op_res_s;
  logic              accept_s;
  logic              out_hs_s;

  // Stage load enables. A stage loads when it is empty or moves on; unrolled,
  // stage k loads if the output is taken or any stage from k onward is empty,
  // which avoids a combinational chain through load_s itself.
  always_comb begin
    logic acc_s;
    load_s = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      acc_s = out_ready;
      for (int j = k; j < STAGES; j++) begin
        acc_s = acc_s | ~valid_r[j];
      end
      load_s[k] = acc_s;
    end
  end

  assign op_res_s = logic_op(in_op, in_a, in_b);
  assign in_ready = load_s[0] & ~rst;
  assign accept_s = in_valid & in_ready;
  assign out_hs_s = valid_r[STAGES-1] & out_ready;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
        // Stage 0 register: loads the freshly computed result on acceptance.
        always_ff @(posedge clk) begin
          if (rst) begin
            valid_r[0] <= 1'b0;
            data_r[0]  <= {WIDTH{1'b0}};
            zero_r[0]  <= 1'b0;
          end else if (load_s[0]) begin
            valid_r[0] <= in_valid;
            if (in_valid) begin
              data_r[0] <= op_res_s;
              zero_r[0] <= zero_detect(op_res_s);
            end else begin
              data_r[0] <= data_r[0];
              zero_r[0] <= zero_r[0];
            end
          end else begin
            valid_r[0] <= valid_r[0];
            data_r[0]  <= data_r[0];
            zero_r[0]  <= zero_r[0];
          end
        end
      end else begin : g_next
        // Stage g register: takes over the previous stage's contents when loading.
        always_ff @(posedge clk) begin
          if (rst) begin
            valid_r[g] <= 1'b0;
            data_r[g]  <= {WIDTH{1'b0}};
            zero_r[g]  <= 1'b0;
          end else if (load_s[g]) begin
            valid_r[g] <= valid_r[g-1];
            if (valid_r[g-1]) begin
              data_r[g] <= data_r[g-1];
              zero_r[g] <= zero_r[g-1];
            end else begin
              data_r[g] <= data_r[g];
              zero_r[g] <= zero_r[g];
            end
          end else begin
            valid_r[g] <= valid_r[g];
            data_r[g]  <= data_r[g];
            zero_r[g]  <= zero_r[g];
          end
        end
      end
    end
  endgenerate

  // Completed-transfer counter; clear wins over increment, saturates at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      xfer_cnt <= {CNT_W{1'b0}};
    end else if (out_hs_s && (xfer_cnt != CNT_MAX)) begin
      xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      xfer_cnt <= xfer_cnt;
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign out_c     = data_r[STAGES-1];
  assign out_zero  = zero_r[STAGES-1];

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed testbench for logic_op_pipe. A default-configured instance and a
// CNT_W=2 instance share the same stimulus; the second one exercises counter
// saturation. Inputs change and outputs are checked on the falling edge.
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic       out_zero;
  logic       cnt_clr;
  logic [15:0] xfer_cnt;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_c2;
  logic       out_zero2;
  logic [1:0] xfer_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_op_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_zero(out_zero),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
  );

  logic_op_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_c(out_c2), .out_zero(out_zero2),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  // Send one transaction with out_ready=1 and check the two-edge latency.
  task automatic one_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] exp_c, input logic exp_z);
    out_ready = 1'b1;
    drive(1'b1, a, b, op);
    tick();
    chk({tag, "_lat"}, {63'd0, out_valid}, 64'd0);
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_c"}, {56'd0, out_c}, {56'd0, exp_c});
    chk({tag, "_zero"}, {63'd0, out_zero}, {63'd0, exp_z});
    tick();
    chk({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    tick();

    // Reset state
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_c", {56'd0, out_c}, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
    chk("rst_cnt", {48'd0, xfer_cnt}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();

    // Operation table
    one_op("and", 8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0);
    one_op("or",  8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0);
    one_op("xor", 8'hF0, 8'h3C, 2'b10, 8'hCC, 1'b0);
    one_op("nand", 8'hF0, 8'h3C, 2'b11, 8'hCF, 1'b0);
    chk("cnt_after_ops", {48'd0, xfer_cnt}, 64'd4);
    chk("cnt2_sat_ops", {62'd0, xfer_cnt2}, 64'd3);

    // Zero flag
    one_op("zero_and", 8'hAA, 8'h55, 2'b00, 8'h00, 1'b1);
    one_op("zero_or",  8'hAA, 8'h55, 2'b01, 8'hFF, 1'b0);
    chk("cnt_after_zero", {48'd0, xfer_cnt}, 64'd6);

    // Clear with no handshake
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", {48'd0, xfer_cnt}, 64'd0);
    chk("clr_cnt2", {62'd0, xfer_cnt2}, 64'd0);

    // Streaming: 10 back-to-back XOR transactions, results t-2 at step t
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t >= 2) begin
        chk("stream_valid", {63'd0, out_valid}, 64'd1);
        chk("stream_c", {56'd0, out_c}, {56'd0, (8'(t - 2) ^ 8'h5A)});
      end else begin
        chk("stream_fill", {63'd0, out_valid}, 64'd0);
      end
      if (t < 10) begin
        drive(1'b1, 8'(t), 8'h5A, 2'b10);
        #1;
        chk("stream_ready", {63'd0, in_ready}, 64'd1);
      end else begin
        drive(1'b0, 8'h00, 8'h00, 2'b00);
      end
      tick();
    end
    chk("stream_done", {63'd0, out_valid}, 64'd0);
    chk("stream_cnt", {48'd0, xfer_cnt}, 64'd10);

    // Backpressure: only two accepted, third held off
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'hFF, 2'b00);
    tick();
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 8'h22, 8'hFF, 2'b00);
    tick();
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_c0", {56'd0, out_c}, 64'h11);
    drive(1'b1, 8'h33, 8'hFF, 2'b00);
    tick();
    chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_c1", {56'd0, out_c}, 64'h11);
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    chk("bp_c2", {56'd0, out_c}, 64'h11);
    chk("bp_v2", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_second_v", {63'd0, out_valid}, 64'd1);
    chk("bp_second_c", {56'd0, out_c}, 64'h22);
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    chk("bp_cnt", {48'd0, xfer_cnt}, 64'd12);

    // Clear coincident with a handshake
    drive(1'b1, 8'h0F, 8'h0F, 2'b01);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    chk("clrhs_valid", {63'd0, out_valid}, 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clrhs_cnt", {48'd0, xfer_cnt}, 64'd0);
    chk("clrhs_cnt2", {62'd0, xfer_cnt2}, 64'd0);

    // Saturation at CNT_W=2 after 5 handshakes
    for (int t = 0; t < 7; t++) begin
      if (t < 5) drive(1'b1, 8'(t), 8'hFF, 2'b00);
      else       drive(1'b0, 8'h00, 8'h00, 2'b00);
      tick();
    end
    chk("sat_cnt2", {62'd0, xfer_cnt2}, 64'd3);
    chk("sat_cnt", {48'd0, xfer_cnt}, 64'd5);

    // Reset with two results in flight
    out_ready = 1'b0;
    drive(1'b1, 8'hA5, 8'hFF, 2'b00);
    tick();
    drive(1'b1, 8'h5A, 8'hFF, 2'b00);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk("mid_full_v", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
    tick();
    rst = 1'b0;
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_out_c", {56'd0, out_c}, 64'd0);
    chk("mid_out_zero", {63'd0, out_zero}, 64'd0);
    chk("mid_cnt", {48'd0, xfer_cnt}, 64'd0);
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("mid_no_stale", {63'd0, out_valid}, 64'd0);
    end
    chk("mid_cnt_end", {48'd0, xfer_cnt}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
